conv_line_buffer: RTL

CONV_LINE_BUFFER -- requirements
Module: conv_line_buffer

---
 rtl/conv_line_buffer_pkg.sv | 15 +
 rtl/conv_lb_row_mem.sv | 25 ++
 rtl/conv_line_buffer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/conv_line_buffer_pkg.sv
// Shared types and helpers for the convolution line buffer.
package conv_line_buffer_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } lb_state_e;

  // Rows that are new in every band after the first.
  function automatic int lb_step(input int sa_units, input int kernel_size);
    return sa_units - (kernel_size - 1);
  endfunction

endpackage

// File: rtl/conv_lb_row_mem.sv
// One image row of storage: synchronous write, combinational read.
module conv_lb_row_mem
  import conv_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/conv_line_buffer.sv
// Banded line buffer: fills SA_Units row slots, then streams column slices
// of the band to the downstream DP array, reusing OVERLAP rows per band.
module conv_line_buffer
  import conv_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SA_Units    = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic                           out_start,
  output logic [DATA_WIDTH*SA_Units-1:0] out_data,
  output logic                           out_last_col,
  output logic                           frame_done
);

  localparam int STEP = lb_step(SA_Units, KERNEL_SIZE);
  localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW   = $clog2(IMG_HEIGHT + 1);
  localparam int SW   = (SA_Units > 1) ? $clog2(SA_Units) : 1;
  localparam int FW   = $clog2(SA_Units + 1);

  lb_state_e                               state_q, state_d;
  logic [CW-1:0]                           col_q, col_d, scol_q, scol_d, rd_col;
  logic [RW-1:0]                           row_cnt_q, row_cnt_d;
  logic [SW-1:0]                           wr_slot_q, wr_slot_d, base_q, base_d, base_adv;
  logic [FW-1:0]                           fill_cnt_q, fill_cnt_d, fill_need;
  logic                                    first_q, first_d;
  logic                                    out_start_q, out_start_d;
  logic                                    out_last_q, out_last_d;
  logic                                    frame_done_q, frame_done_d;
  logic [SA_Units-1:0][DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic [SA_Units-1:0][DATA_WIDTH-1:0]     rd_data, lane_data;
  logic [SW:0]                             base_sum;
  logic                                    accept;

  assign accept    = in_valid && (state_q == FILL);
  assign fill_need = first_q ? FW'(SA_Units) : FW'(STEP);

  // Column to read for the next registered slice; column 0 while filling.
  assign rd_col = (state_q == STREAM && scol_q != CW'(IMG_WIDTH - 1)) ? scol_q + CW'(1) : '0;

  assign base_sum = {1'b0, base_q} + (SW+1)'(STEP);
  assign base_adv = (base_sum >= (SW+1)'(SA_Units)) ? SW'(base_sum - (SW+1)'(SA_Units))
                                                    : SW'(base_sum);

  for (genvar g = 0; g < SA_Units; g++) begin : g_row
    logic [SW:0] slot_sum;
    logic [SW-1:0] slot;

    conv_lb_row_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .IMG_WIDTH (IMG_WIDTH),
      .ADDR_W    (CW)
    ) u_row (
      .clk    (clk),
      .we     (accept && (wr_slot_q == SW'(g))),
      .wr_addr(col_q),
      .wr_data(in_data),
      .rd_addr(rd_col),
      .rd_data(rd_data[g])
    );

    // Lane g shows slot (base+g) mod SA_Units, i.e. band row g.
    assign slot_sum     = {1'b0, base_q} + (SW+1)'(g);
    assign slot         = (slot_sum >= (SW+1)'(SA_Units)) ? SW'(slot_sum - (SW+1)'(SA_Units))
                                                          : SW'(slot_sum);
    assign lane_data[g] = rd_data[slot];
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    scol_d       = scol_q;
    row_cnt_d    = row_cnt_q;
    wr_slot_d    = wr_slot_q;
    base_d       = base_q;
    fill_cnt_d   = fill_cnt_q;
    first_d      = first_q;
    out_start_d  = out_start_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (col_q == CW'(IMG_WIDTH - 1)) begin
            col_d     = '0;
            row_cnt_d = row_cnt_q + RW'(1);
            wr_slot_d = (wr_slot_q == SW'(SA_Units - 1)) ? '0 : wr_slot_q + SW'(1);
            if (fill_cnt_q + FW'(1) == fill_need) begin
              fill_cnt_d  = '0;
              first_d     = 1'b0;
              state_d     = STREAM;
              scol_d      = '0;
              out_start_d = 1'b1;
              out_last_d  = (IMG_WIDTH == 1);
              out_data_d  = lane_data;
            end else begin
              fill_cnt_d = fill_cnt_q + FW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      STREAM: begin
        if (scol_q == CW'(IMG_WIDTH - 1)) begin
          state_d      = GAP;
          out_start_d  = 1'b0;
          out_last_d   = 1'b0;
          frame_done_d = (row_cnt_q == RW'(IMG_HEIGHT));
        end else begin
          scol_d     = rd_col;
          out_data_d = lane_data;
          out_last_d = (rd_col == CW'(IMG_WIDTH - 1));
        end
      end
      GAP: begin
        state_d = FILL;
        if (frame_done_q) begin
          base_d    = '0;
          row_cnt_d = '0;
          wr_slot_d = '0;
          first_d   = 1'b1;
        end else begin
          base_d = base_adv;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      col_q        <= '0;
      scol_q       <= '0;
      row_cnt_q    <= '0;
      wr_slot_q    <= '0;
      base_q       <= '0;
      fill_cnt_q   <= '0;
      first_q      <= 1'b1;
      out_start_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      scol_q       <= scol_d;
      row_cnt_q    <= row_cnt_d;
      wr_slot_q    <= wr_slot_d;
      base_q       <= base_d;
      fill_cnt_q   <= fill_cnt_d;
      first_q      <= first_d;
      out_start_q  <= out_start_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready     = (state_q == FILL);
  assign out_start    = out_start_q;
  assign out_last_col = out_last_q;
  assign out_data     = out_data_q;
  assign frame_done   = frame_done_q;

endmodule
